// File: rtl/max7219_spi_tx.sv
// max7219_spi_tx: serializes {addr_in, din} MSB-first to a MAX7219 over CS/SCK/DIN.
// Optional build macro MAX7219_TX_QUEUE_EN adds a one-entry pending frame so a
// new request can be taken mid-frame and launched straight out of GAP.
module max7219_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        din,
  input  logic              start,
  output logic              cs,
  output logic              sck,
  output logic              dout,
  output logic              busy,
  output logic              done
);
  localparam int FW = ADDR_W + 8;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FW);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("CLK_DIV must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bitc, bitc_n;
  logic [FW-1:0]   sr, sr_n, fin, ldata;
  logic            cs_n, sck_n, dout_n, busy_n, done_n, last, load;
`ifdef MAX7219_TX_QUEUE_EN
  logic            pend_v, pend_v_n;
  logic [FW-1:0]   pend, pend_n;
`endif

  assign fin  = {addr_in, din};
  assign last = cnt == CW'(CLK_DIV - 1);

  // State, counters, shift register and every output are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sr    <= '0;
      cs    <= 1'b1;
      sck   <= 1'b0;
      dout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MAX7219_TX_QUEUE_EN
      pend_v <= 1'b0;
      pend   <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bitc_n;
      sr    <= sr_n;
      cs    <= cs_n;
      sck   <= sck_n;
      dout  <= dout_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef MAX7219_TX_QUEUE_EN
      pend_v <= pend_v_n;
      pend   <= pend_n;
`endif
    end
  end

  // Next-state logic: sck itself marks the phase; dout only moves when a low phase begins.
  always_comb begin
    state_n = state;
    cnt_n   = (state == IDLE || last) ? '0 : cnt + 1'b1;
    bitc_n  = bitc;
    sr_n    = sr;
    cs_n    = cs;
    sck_n   = sck;
    dout_n  = dout;
    done_n  = 1'b0;
    load    = 1'b0;
    ldata   = fin;
    case (state)
      IDLE: begin
        cs_n  = 1'b1;
        sck_n = 1'b0;
      end
      SHIFT: begin
        if (last) begin
          if (!sck) begin
            sck_n = 1'b1;
          end else if (bitc == '0) begin
            sck_n   = 1'b0;
            state_n = TAIL;
          end else begin
            sck_n  = 1'b0;
            bitc_n = bitc - 1'b1;
            sr_n   = sr << 1;
            dout_n = sr[FW-2];
          end
        end
      end
      TAIL: begin
        if (last) begin
          state_n = GAP;
          cs_n    = 1'b1;
          dout_n  = 1'b0;
        end
      end
      GAP: begin
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
`ifdef MAX7219_TX_QUEUE_EN
    pend_v_n = pend_v;
    pend_n   = pend;
    if (state == GAP && last && pend_v) begin
      load     = 1'b1;
      ldata    = pend;
      pend_v_n = 1'b0;
    end else if (start && !pend_v && (state == IDLE || (state == GAP && last))) begin
      load = 1'b1;
    end else if (start && !pend_v && state != IDLE) begin
      pend_v_n = 1'b1;
      pend_n   = fin;
    end
`else
    load = start && state == IDLE;
`endif
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      bitc_n  = BW'(FW - 1);
      sr_n    = ldata;
      cs_n    = 1'b0;
      sck_n   = 1'b0;
      dout_n  = ldata[FW-1];
    end
`ifdef MAX7219_TX_QUEUE_EN
    busy_n = state_n != IDLE && pend_v_n;
`else
    busy_n = state_n != IDLE;
`endif
  end
endmodule

// File: tb/tb_max7219_spi_tx.sv
// tb_max7219_spi_tx: directed checks of frame timing, data order, back-to-back and reset behaviour.
module tb_max7219_spi_tx;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic start4 = 1'b0, start1 = 1'b0, sel = 1'b0;
  logic cs4, sck4, dout4, busy4, done4;
  logic cs1, sck1, dout1, busy1, done1;
  logic mcs, msck, mdout, mbusy, mdone;

  int n_cmp = 0, n_fail = 0;
  int cs_cnt, cs_last, busy_first, busy_last, busy_cnt, done_cnt, done_first;
  int nrise, rise1, rise2, nfall;
  int fall_at [4];
  logic [63:0] bits;
  logic prev_sck, prev_cs;

  always #5 clk = ~clk;

  max7219_spi_tx #(.CLK_DIV(4), .ADDR_W(8)) d4 (
    .clk(clk), .rst(rst), .addr_in(addr), .din(din), .start(start4),
    .cs(cs4), .sck(sck4), .dout(dout4), .busy(busy4), .done(done4));

  max7219_spi_tx #(.CLK_DIV(1), .ADDR_W(8)) d1 (
    .clk(clk), .rst(rst), .addr_in(addr), .din(din), .start(start1),
    .cs(cs1), .sck(sck1), .dout(dout1), .busy(busy1), .done(done1));

  assign mcs   = sel ? cs1   : cs4;
  assign msck  = sel ? sck1  : sck4;
  assign mdout = sel ? dout1 : dout4;
  assign mbusy = sel ? busy1 : busy4;
  assign mdone = sel ? done1 : done4;

  // Launch a frame at the next edge (cycle 0) and record cycles 1..ncyc.
  // start stays high while c < hold_until, and is pulsed with a2/d2 at pulse_at.
  task automatic run(input logic s1, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] a2, input logic [7:0] d2,
                     input int ncyc, input int hold_until, input int pulse_at);
    logic st;
    cs_cnt = 0; cs_last = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
    done_cnt = 0; done_first = 0; nrise = 0; rise1 = 0; rise2 = 0; nfall = 0;
    for (int i = 0; i < 4; i++) fall_at[i] = 0;
    bits = '0; prev_sck = 1'b0; prev_cs = 1'b1;
    sel = s1; addr = a; din = d;
    start4 = !s1; start1 = s1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      st = (c < hold_until) || (c == pulse_at);
      if (c == pulse_at) begin addr = a2; din = d2; end
      start4 = st && !s1;
      start1 = st && s1;
      if (!mcs) begin
        cs_cnt++; cs_last = c;
        if (prev_cs) begin if (nfall < 4) fall_at[nfall] = c; nfall++; end
      end
      if (mbusy) begin if (busy_cnt == 0) busy_first = c; busy_last = c; busy_cnt++; end
      if (mdone) begin if (done_cnt == 0) done_first = c; done_cnt++; end
      if (msck && !prev_sck) begin
        bits = {bits[62:0], mdout};
        if (nrise == 0) rise1 = c;
        if (nrise == 1) rise2 = c;
        nrise++;
      end
      prev_sck = msck; prev_cs = mcs;
    end
    start4 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs4 !== 1'b1) begin n_fail++; $display("FAIL reset_cs got %b want 1", cs4); end
    n_cmp++; if (sck4 !== 1'b0) begin n_fail++; $display("FAIL reset_sck got %b want 0", sck4); end
    n_cmp++; if (dout4 !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %b want 0", dout4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy4); end
    n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done4); end
    n_cmp++; if (cs1 !== 1'b1) begin n_fail++; $display("FAIL reset_cs1 got %b want 1", cs1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    run(1'b0, 8'h0C, 8'h01, 8'h00, 8'h00, 140, 1, -1);
    n_cmp++; if (fall_at[0] !== 1) begin n_fail++; $display("FAIL single_cs_fall got %0d want 1", fall_at[0]); end
    n_cmp++; if (cs_last !== 132) begin n_fail++; $display("FAIL single_cs_last got %0d want 132", cs_last); end
    n_cmp++; if (cs_cnt !== 132) begin n_fail++; $display("FAIL single_cs_cnt got %0d want 132", cs_cnt); end
    n_cmp++; if (nrise !== 16) begin n_fail++; $display("FAIL single_rises got %0d want 16", nrise); end
    n_cmp++; if (bits[15:0] !== 16'h0C01) begin n_fail++; $display("FAIL single_bits got %h want 0c01", bits[15:0]); end
    n_cmp++; if (rise1 !== 5) begin n_fail++; $display("FAIL single_rise1 got %0d want 5", rise1); end
`ifdef MAX7219_TX_QUEUE_EN
    n_cmp++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL single_busy_cnt got %0d want 0", busy_cnt); end
`else
    n_cmp++; if (busy_first !== 1) begin n_fail++; $display("FAIL single_busy_first got %0d want 1", busy_first); end
    n_cmp++; if (busy_last !== 136) begin n_fail++; $display("FAIL single_busy_last got %0d want 136", busy_last); end
    n_cmp++; if (busy_cnt !== 136) begin n_fail++; $display("FAIL single_busy_cnt got %0d want 136", busy_cnt); end
`endif
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (done_first !== 137) begin n_fail++; $display("FAIL single_done_at got %0d want 137", done_first); end
  endtask

  task automatic test_div1;
    run(1'b1, 8'h0A, 8'h0F, 8'h00, 8'h00, 40, 1, -1);
    n_cmp++; if (nrise !== 16) begin n_fail++; $display("FAIL div1_rises got %0d want 16", nrise); end
    n_cmp++; if (bits[15:0] !== 16'h0A0F) begin n_fail++; $display("FAIL div1_bits got %h want 0a0f", bits[15:0]); end
    n_cmp++; if (rise1 !== 2) begin n_fail++; $display("FAIL div1_rise1 got %0d want 2", rise1); end
    n_cmp++; if (rise2 - rise1 !== 2) begin n_fail++; $display("FAIL div1_period got %0d want 2", rise2 - rise1); end
    n_cmp++; if (cs_last !== 33) begin n_fail++; $display("FAIL div1_cs_last got %0d want 33", cs_last); end
    n_cmp++; if (done_first !== 35) begin n_fail++; $display("FAIL div1_done_at got %0d want 35", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL div1_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
`ifdef MAX7219_TX_QUEUE_EN
    run(1'b0, 8'h0B, 8'h07, 8'h0B, 8'h07, 420, 273, -1);
    n_cmp++; if (fall_at[1] !== 137) begin n_fail++; $display("FAIL b2b_fall2 got %0d want 137", fall_at[1]); end
    n_cmp++; if (fall_at[2] !== 273) begin n_fail++; $display("FAIL b2b_fall3 got %0d want 273", fall_at[2]); end
`else
    run(1'b0, 8'h0B, 8'h07, 8'h0B, 8'h07, 420, 411, -1);
    n_cmp++; if (fall_at[1] !== 138) begin n_fail++; $display("FAIL b2b_fall2 got %0d want 138", fall_at[1]); end
    n_cmp++; if (fall_at[2] !== 275) begin n_fail++; $display("FAIL b2b_fall3 got %0d want 275", fall_at[2]); end
`endif
    n_cmp++; if (nfall !== 3) begin n_fail++; $display("FAIL b2b_frames got %0d want 3", nfall); end
    n_cmp++; if (done_cnt !== 3) begin n_fail++; $display("FAIL b2b_done_cnt got %0d want 3", done_cnt); end
    n_cmp++; if (nrise !== 48) begin n_fail++; $display("FAIL b2b_rises got %0d want 48", nrise); end
    n_cmp++; if (cs_cnt !== 396) begin n_fail++; $display("FAIL b2b_cs_cnt got %0d want 396", cs_cnt); end
    n_cmp++; if (bits[47:0] !== 48'h0B070B070B07) begin n_fail++; $display("FAIL b2b_bits got %h want 0b070b070b07", bits[47:0]); end
  endtask

  task automatic test_mid_start;
    run(1'b0, 8'h0C, 8'h01, 8'h01, 8'h08, 300, 1, 20);
`ifdef MAX7219_TX_QUEUE_EN
    n_cmp++; if (busy_first !== 21) begin n_fail++; $display("FAIL mid_busy_first got %0d want 21", busy_first); end
    n_cmp++; if (busy_last !== 136) begin n_fail++; $display("FAIL mid_busy_last got %0d want 136", busy_last); end
    n_cmp++; if (fall_at[1] !== 137) begin n_fail++; $display("FAIL mid_fall2 got %0d want 137", fall_at[1]); end
    n_cmp++; if (done_cnt !== 2) begin n_fail++; $display("FAIL mid_done_cnt got %0d want 2", done_cnt); end
    n_cmp++; if (nrise !== 32) begin n_fail++; $display("FAIL mid_rises got %0d want 32", nrise); end
    n_cmp++; if (bits[31:0] !== 32'h0C010108) begin n_fail++; $display("FAIL mid_bits got %h want 0c010108", bits[31:0]); end
`else
    n_cmp++; if (nfall !== 1) begin n_fail++; $display("FAIL mid_frames got %0d want 1", nfall); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (nrise !== 16) begin n_fail++; $display("FAIL mid_rises got %0d want 16", nrise); end
    n_cmp++; if (bits[15:0] !== 16'h0C01) begin n_fail++; $display("FAIL mid_bits got %h want 0c01", bits[15:0]); end
    n_cmp++; if (busy_last !== 136) begin n_fail++; $display("FAIL mid_busy_last got %0d want 136", busy_last); end
`endif
  endtask

  task automatic test_reset_mid;
    run(1'b0, 8'h0C, 8'h01, 8'h00, 8'h00, 59, 1, -1);
    @(negedge clk);
    n_cmp++; if (cs4 !== 1'b0) begin n_fail++; $display("FAIL rmid_cs_before got %b want 0", cs4); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cs4 !== 1'b1) begin n_fail++; $display("FAIL rmid_cs got %b want 1", cs4); end
    n_cmp++; if (sck4 !== 1'b0) begin n_fail++; $display("FAIL rmid_sck got %b want 0", sck4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy4); end
    n_cmp++; if (dout4 !== 1'b0) begin n_fail++; $display("FAIL rmid_dout got %b want 0", dout4); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(1'b0, 8'h05, 8'hA3, 8'h00, 8'h00, 140, 1, -1);
    n_cmp++; if (fall_at[0] !== 1) begin n_fail++; $display("FAIL rmid_fall got %0d want 1", fall_at[0]); end
    n_cmp++; if (nrise !== 16) begin n_fail++; $display("FAIL rmid_rises got %0d want 16", nrise); end
    n_cmp++; if (bits[15:0] !== 16'h05A3) begin n_fail++; $display("FAIL rmid_bits got %h want 05a3", bits[15:0]); end
    n_cmp++; if (done_first !== 137) begin n_fail++; $display("FAIL rmid_done_at got %0d want 137", done_first); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_div1;
    test_back_to_back;
    test_mid_start;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/max7219_spi_tx.md
Name: max7219_spi_tx

Overview:
Frame serializer directly downstream of the display controller, which drives it through the start/busy handshake. Accepts one 8-bit register address and one 8-bit data byte per transaction. Shifts the 16-bit frame out MSB-first on a three-wire bus (CS, SCK, DIN) to a MAX7219. Generates SCK by dividing the system clock and enforces CS setup, latch and inter-frame gap timing.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period; legal range 1..255; 0 is a compile-time error
ADDR_W, 8, width of addr_in; frame = {addr_in, din}

Ports:
clk  input  1  system clock, single clock domain (12 MHz in current build)
rst  input  1  asynchronous, active-low reset
addr_in  input  8  register address; upper nibble is don't-care to the MAX7219 but is still shifted out
din  input  8  register data
start  input  1  request; accepted on a rising clk edge when start=1 and busy=0
cs  output  1  chip select, active low
sck  output  1  serial clock, idle low
dout  output  1  serial data to MAX7219 DIN
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst=0, asynchronous): cs=1, sck=0, dout=0, busy=0, done=0, state=IDLE, all counters cleared. Takes effect immediately, including mid-frame; the aborted frame is discarded. After reset releases, the first edge can accept start.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE -> SHIFT -> TAIL -> GAP -> IDLE.
- IDLE:
  - cs=1, sck=0, busy=0.
  - On start=1, latch {addr_in,din} into a 16-bit shift register, load the bit counter with 15, and go to SHIFT.
  - Call the accept edge cycle 0. Inputs are not sampled again until the next accept.
- SHIFT:
  - Cycle 1: cs=0, busy=1, dout=frame[15], sck=0.
  - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - dout changes only at the start of a low phase, so it is stable across every SCK rising edge.
  - Bits go out 15 down to 0. After the high phase of bit 0, go to TAIL.
  - SHIFT spans cycles 1..32*CLK_DIV.
- TAIL: sck=0, cs=0 for CLK_DIV cycles (hold time after the last rising edge). dout holds bit 0.
- GAP:
  - cs=1 (the rising CS edge latches the MAX7219), sck=0, dout=0 for CLK_DIV cycles.
  - Then go to IDLE. busy=0 and done=1 for exactly one cycle, at cycle 34*CLK_DIV+1.
- start is ignored while busy=1.
- start held high continuously: a new frame is accepted in the same cycle done=1. Back-to-back frames are therefore separated by CLK_DIV cycles of cs=1 plus one IDLE cycle.
- Counters: half-period counter width is clog2(CLK_DIV+1); bit counter is 4 bits and must not wrap past 0.

Optional Feature:
MAX7219_TX_QUEUE_EN
- Defined:
  - Adds a one-entry pending register. start is accepted whenever the pending slot is empty, including mid-frame.
  - busy = (frame active) AND (pending slot full).
  - On leaving GAP with the slot full, the pending frame loads and SHIFT begins on the next cycle, with no IDLE cycle.
  - done still pulses once per completed frame.
  - Reset clears the pending slot.
- Not defined:
  - Behaviour exactly as above.
  - busy = frame active.

Test Plan:
- Reset then single frame: CLK_DIV=4, addr_in=0x0C, din=0x01, start for one cycle. Required: cs low over cycles 1..132; dout sampled at the 16 SCK rising edges = 0000_1100_0000_0001; busy high for cycles 1..136; done=1 only at cycle 137.
- CLK_DIV=1, addr_in=0x0A, din=0x0F. Required: SCK period of 2 clk cycles; 16 rising edges; dout bits = 0x0A0F; done at cycle 35.
- start held high for 3 frames (0x0B/0x07). Required: 3 identical frames, each separated by 4 cs-high cycles + 1 idle cycle; exactly 3 done pulses.
- start asserted mid-frame (queue disabled). Required: ignored; exactly one frame is emitted.
- rst asserted at cycle 60 of a frame. Required: cs=1, sck=0, busy=0 asynchronously in the same cycle; the next start after release emits a full 16-bit frame from bit 15.
- MAX7219_TX_QUEUE_EN defined; second start (0x01/0x08) at cycle 20. Required: busy=1 from cycle 21; the second frame's cs falls at cycle 137 with no idle gap; 2 done pulses.
